// File: rtl/thumb_fetch_aligner_pkg.sv
// Shared definitions for the Thumb fetch aligner.
//   - instruction / address widths
//   - ARM/Thumb state encoding
//   - BL prefix opcode pattern and a helper to spot it
//   - queue entry layout (word address + instruction word)
package thumb_fetch_aligner_pkg;

  localparam int INST_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int WADDR_W = ADDR_W - 2;

  // Thumb BL prefix: halfword[15:11] == 5'b11110
  localparam logic [4:0] THUMB_BL_PREFIX = 5'b11110;

  typedef enum logic {
    MODE_ARM   = 1'b0,
    MODE_THUMB = 1'b1
  } mode_e;

  typedef struct packed {
    logic [WADDR_W-1:0] waddr;
    logic [INST_W-1:0]  data;
  } fetch_entry_t;

  function automatic logic is_bl_prefix(input logic [15:0] hw);
    return hw[15:11] == THUMB_BL_PREFIX;
  endfunction

endpackage

// File: rtl/thumb_fetch_aligner_if.sv
// Bus bundle for the fetch aligner: fetch-side push handshake, flush/redirect,
// and decode-side beat handshake.
//   slave  : the aligner itself
//   master : fetch unit + decoder (the environment driving the aligner)
interface thumb_fetch_aligner_if;
  import thumb_fetch_aligner_pkg::*;

  logic              fetch_valid;
  logic              fetch_ready;
  logic [INST_W-1:0] fetch_data;
  logic [ADDR_W-1:0] fetch_addr;

  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic              flush_thumb;

  logic              dec_valid;
  logic              dec_ready;
  logic [INST_W-1:0] dec_code;
  logic [ADDR_W-1:0] dec_pc;
  logic              dec_thumb;
  logic              dec_pair;

  modport slave (
    input  fetch_valid, fetch_data, fetch_addr,
    input  flush, flush_pc, flush_thumb,
    input  dec_ready,
    output fetch_ready,
    output dec_valid, dec_code, dec_pc, dec_thumb, dec_pair
  );

  modport master (
    output fetch_valid, fetch_data, fetch_addr,
    output flush, flush_pc, flush_thumb,
    output dec_ready,
    input  fetch_ready,
    input  dec_valid, dec_code, dec_pc, dec_thumb, dec_pair
  );

endinterface

// File: rtl/thumb_fetch_aligner_inst_word_fifo.sv
// inst_word_fifo: DEPTH-entry queue of {word address, instruction word}.
// Ports:
//   clk, rst    clock, synchronous active-high reset (clears entries too)
//   clr         synchronous clear of pointers/count (flush); entries kept
//   push/push_entry   write at tail (caller guarantees not full)
//   pop               advance head (caller guarantees not empty)
//   count             occupancy, 0..DEPTH
//   head, head_next   entries at head and head+1 (head_next valid if count>=2)
module inst_word_fifo
  import thumb_fetch_aligner_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output fetch_entry_t               head,
  output fetch_entry_t               head_next
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr, rd_nxt;

  // power-of-2 depth: pointers wrap by natural overflow
  assign rd_nxt    = rd_ptr + PW'(1);
  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_nxt];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_nxt;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/thumb_fetch_aligner.sv
// thumb_fetch_aligner: buffers word-aligned fetch data and emits one ARM word
// or one Thumb halfword (low half first) per beat, each with its own PC.
// A flush discards the queue and restarts at flush_pc in the flush_thumb state.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        thumb_fetch_aligner_if.slave (fetch_*, flush*, dec_*)
// Parameters:
//   DEPTH      queue entries (power of 2, >= 2)
// Build option:
//   THUMB_BL_FUSE_EN  when defined, a Thumb BL prefix halfword is held until its
//                     suffix is queued and both leave as one beat ({suffix,prefix},
//                     dec_pair=1). Undefined: dec_pair=0, halves leave separately.
module thumb_fetch_aligner
  import thumb_fetch_aligner_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  thumb_fetch_aligner_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] count;
  fetch_entry_t  head, head_next, push_entry;
  mode_e         mode;
  logic          hw_sel;
  logic          push, pop, dec_fire;
  logic          pair_ok, fuse;
  logic [15:0]   cur_hw;

  assign push_entry = '{waddr: bus.fetch_addr[ADDR_W-1:2], data: bus.fetch_data};

  inst_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clr        (bus.flush),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .head       (head),
    .head_next  (head_next)
  );

  assign cur_hw = hw_sel ? head.data[31:16] : head.data[15:0];

  // Output decode straight from the head entry; flush already masks valid/ready
  always_comb begin
    pair_ok      = 1'b1;
    fuse         = 1'b0;
    bus.dec_pair = 1'b0;
    bus.dec_code = head.data;
    bus.dec_pc   = {head.waddr, 2'b00};
    if (mode == MODE_THUMB) begin
      bus.dec_code = {16'h0, cur_hw};
      bus.dec_pc   = {head.waddr, hw_sel, 1'b0};
`ifdef THUMB_BL_FUSE_EN
      if (is_bl_prefix(cur_hw)) begin
        fuse         = 1'b1;
        bus.dec_pair = 1'b1;
        if (hw_sel) begin
          // suffix lives in the low half of the next entry
          bus.dec_code = {head_next.data[15:0], cur_hw};
          pair_ok      = (count >= CW'(2));
        end else begin
          bus.dec_code = head.data;
        end
      end
`endif
    end
  end

`ifndef THUMB_BL_FUSE_EN
  logic unused_next;
  assign unused_next = ^head_next;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.fetch_addr[1:0], bus.flush_pc[31:2], bus.flush_pc[0]};

  assign bus.fetch_ready = (count != CW'(DEPTH)) & ~bus.flush;
  assign bus.dec_valid   = (count != '0) & ~bus.flush & pair_ok;
  assign bus.dec_thumb   = mode;

  assign push     = bus.fetch_valid & bus.fetch_ready;
  assign dec_fire = bus.dec_valid & bus.dec_ready;
  // a fused beat always consumes exactly one word and leaves hw_sel alone
  assign pop      = dec_fire & ((mode == MODE_ARM) | hw_sel | fuse);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode   <= MODE_ARM;
      hw_sel <= 1'b0;
    end else if (bus.flush) begin
      mode   <= mode_e'(bus.flush_thumb);
      hw_sel <= bus.flush_thumb & bus.flush_pc[1];
    end else if (dec_fire && mode == MODE_THUMB && !fuse) begin
      hw_sel <= ~hw_sel;
    end
  end

endmodule

// File: tb/tb_thumb_fetch_aligner.sv
// Directed bench for thumb_fetch_aligner. Stimulus pushes expected beats into
// a scoreboard queue; a negedge monitor pops and compares every accepted beat.
module tb_thumb_fetch_aligner;

`ifdef THUMB_BL_FUSE_EN
  localparam bit FUSE = 1'b1;
`else
  localparam bit FUSE = 1'b0;
`endif

  typedef struct {
    logic [31:0] code;
    logic [31:0] pc;
    logic        thumb;
    logic        pair;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  thumb_fetch_aligner_if bus();

  thumb_fetch_aligner #(.DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input logic [31:0] code, input logic [31:0] pc,
                             input logic thumb, input logic pair);
    beat_t b;
    b.code = code; b.pc = pc; b.thumb = thumb; b.pair = pair;
    exp_q.push_back(b);
  endtask

  // monitor: every accepted beat must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && bus.dec_valid && bus.dec_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat_pc", bus.dec_pc, 32'hxxxx_xxxx);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        check("beat", {bus.dec_code, bus.dec_pc[29:0], bus.dec_thumb, bus.dec_pair},
              {b.code, b.pc[29:0], b.thumb, b.pair});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // offer one word; bounded wait for fetch_ready
  task automatic push(input logic [31:0] d, input logic [31:0] a);
    int n = 0;
    bus.fetch_valid = 1'b1;
    bus.fetch_data  = d;
    bus.fetch_addr  = a;
    @(negedge clk);
    while (!bus.fetch_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.fetch_ready) check("push_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.fetch_valid = 1'b0;
  endtask

  task automatic do_flush(input logic [31:0] pc, input logic thumb);
    bus.flush       = 1'b1;
    bus.flush_pc    = pc;
    bus.flush_thumb = thumb;
    @(negedge clk);
    check("flush_dec_valid", 32'(bus.dec_valid), 32'd0);
    check("flush_fetch_ready", 32'(bus.fetch_ready), 32'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
  endtask

  initial begin
    bus.fetch_valid = 1'b0; bus.fetch_data = '0; bus.fetch_addr = '0;
    bus.flush = 1'b0; bus.flush_pc = '0; bus.flush_thumb = 1'b0;
    bus.dec_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_dec_valid",   32'(bus.dec_valid), 32'd0);
    check("rst_dec_code",    bus.dec_code, 32'd0);
    check("rst_dec_pc",      bus.dec_pc, 32'd0);
    check("rst_dec_thumb",   32'(bus.dec_thumb), 32'd0);
    check("rst_dec_pair",    32'(bus.dec_pair), 32'd0);
    check("rst_fetch_ready", 32'(bus.fetch_ready), 32'd1);
    @(posedge clk); #1;

    // 1: ARM stream, one-cycle latency
    expect_beat(32'hE3A00001, 32'h100, 1'b0, 1'b0);
    expect_beat(32'hE2800002, 32'h104, 1'b0, 1'b0);
    push(32'hE3A00001, 32'h100);
    @(negedge clk);
    check("arm_latency_valid", 32'(bus.dec_valid), 32'd1);
    @(posedge clk); #1;
    push(32'hE2800002, 32'h104);
    idle(3);

    // 2: Thumb starting on the upper halfword
    do_flush(32'h202, 1'b1);
    expect_beat(32'h2001, 32'h202, 1'b1, 1'b0);
    expect_beat(32'hBF00, 32'h204, 1'b1, 1'b0);
    expect_beat(32'h46C0, 32'h206, 1'b1, 1'b0);
    push(32'h20014770, 32'h200);
    push(32'h46C0BF00, 32'h204);
    idle(4);

    // 3: backpressure, third word held until space frees
    do_flush(32'h400, 1'b0);
    bus.dec_ready = 1'b0;
    expect_beat(32'hAAAA0001, 32'h400, 1'b0, 1'b0);
    expect_beat(32'hBBBB0002, 32'h404, 1'b0, 1'b0);
    expect_beat(32'hCCCC0003, 32'h408, 1'b0, 1'b0);
    push(32'hAAAA0001, 32'h400);
    push(32'hBBBB0002, 32'h404);
    bus.fetch_valid = 1'b1; bus.fetch_data = 32'hCCCC0003; bus.fetch_addr = 32'h408;
    @(negedge clk);
    check("full_fetch_ready", 32'(bus.fetch_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("full_fetch_ready_hold", 32'(bus.fetch_ready), 32'd0);
    @(posedge clk); #1;
    bus.dec_ready = 1'b1;
    push(32'hCCCC0003, 32'h408);
    idle(4);

    // 4: flush with 2 queued and a word offered in the flush cycle
    bus.dec_ready = 1'b0;
    push(32'h0BAD0001, 32'h480);
    push(32'h0BAD0002, 32'h484);
    bus.fetch_valid = 1'b1; bus.fetch_data = 32'hDEADBEEF; bus.fetch_addr = 32'h488;
    do_flush(32'h504, 1'b0);
    bus.fetch_valid = 1'b0;
    bus.dec_ready = 1'b1;
    @(negedge clk);
    check("post_flush_dec_valid", 32'(bus.dec_valid), 32'd0);
    check("post_flush_fetch_ready", 32'(bus.fetch_ready), 32'd1);
    @(posedge clk); #1;
    expect_beat(32'h11112222, 32'h504, 1'b0, 1'b0);
    push(32'h11112222, 32'h504);
    idle(3);

    // 5a: BL pair inside one word
    do_flush(32'h300, 1'b1);
    if (FUSE) begin
      expect_beat(32'hF800F000, 32'h300, 1'b1, 1'b1);
    end else begin
      expect_beat(32'hF000, 32'h300, 1'b1, 1'b0);
      expect_beat(32'hF800, 32'h302, 1'b1, 1'b0);
    end
    push(32'hF800F000, 32'h300);
    idle(3);

    // 5b: prefix in upper half, suffix in the next word
    do_flush(32'h302, 1'b1);
    if (FUSE) begin
      expect_beat(32'hF800F000, 32'h302, 1'b1, 1'b1);
    end else begin
      expect_beat(32'hF000, 32'h302, 1'b1, 1'b0);
      expect_beat(32'hF800, 32'h304, 1'b1, 1'b0);
    end
    expect_beat(32'h0000, 32'h306, 1'b1, 1'b0);
    push(32'hF0000000, 32'h300);
    @(negedge clk);
    check("straddle_valid", 32'(bus.dec_valid), FUSE ? 32'd0 : 32'd1);
    @(posedge clk); #1;
    idle(2);
    @(negedge clk);
    check("straddle_stall", 32'(bus.dec_valid), 32'd0);
    @(posedge clk); #1;
    push(32'h0000F800, 32'h304);
    idle(4);

    // 6: reset with two entries queued in Thumb state
    bus.dec_ready = 1'b0;
    do_flush(32'h600, 1'b1);
    push(32'h55556666, 32'h600);
    push(32'h77778888, 32'h604);
    @(negedge clk);
    check("pre_rst_fetch_ready", 32'(bus.fetch_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_dec_valid",   32'(bus.dec_valid), 32'd0);
    check("mid_rst_dec_thumb",   32'(bus.dec_thumb), 32'd0);
    check("mid_rst_fetch_ready", 32'(bus.fetch_ready), 32'd1);
    @(posedge clk); #1;
    bus.dec_ready = 1'b1;
    expect_beat(32'h12345678, 32'h700, 1'b0, 1'b0);
    push(32'h12345678, 32'h700);

    // drain: every expected beat must have appeared
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    check("scoreboard_left", 32'(exp_q.size()), 32'd0);
    idle(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
